// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, opcode field position, instruction width.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_MOV  = 4'b0011,
    OP_MVI  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_STA  = 4'b1000,
    OP_LDA  = 4'b1001,
    OP_JMP  = 4'b1010,
    OP_JZ   = 4'b1011,
    OP_JC   = 4'b1100,
    OP_RSVD = 4'b1101,
    OP_RSVE = 4'b1110,
    OP_HALT = 4'b1111
  } opcode_e;

endpackage

// File: rtl/wb_decode.sv
// Combinational write-back decode: opcode -> register-write enable and data-source select.
module wb_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic       wbr_d,
  output logic       wbin_d
);

  // Decode opcode; unknown or non-writing opcodes fall to the no-write default.
  always_comb begin
    wbr_d  = 1'b0;
    wbin_d = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MOV, OP_MVI,
      OP_AND, OP_OR,  OP_XOR: begin
        wbr_d  = 1'b1;
        wbin_d = 1'b0;
      end
      OP_LDA: begin
        wbr_d  = 1'b1;
        wbin_d = 1'b1;
      end
      default: begin
        wbr_d  = 1'b0;
        wbin_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back control stage: registers the decoded write strobes on each t3 rise.
// Build option: WB_LOAD_EN enables the LDA memory write-back path; when undefined,
// wbin is constant 0 and LDA performs no register write.
module wb_ctrl
  import cpu_pkg::*;
(
  input  logic               t3,
  input  logic               rst,
  input  logic [INSTR_W-1:0] ir,
  output logic               wbr,
  output logic               wbin
);

  logic dec_wbr;
  logic dec_wbin;
  logic wbr_d;
  logic wbr_q;
  logic unused_ir_bits;

  assign unused_ir_bits = ^ir[OP_LSB-1:0];

  wb_decode u_decode (
    .op     (ir[OP_MSB:OP_LSB]),
    .wbr_d  (dec_wbr),
    .wbin_d (dec_wbin)
  );

`ifdef WB_LOAD_EN
  logic wbin_d;
  logic wbin_q;

  // Load path enabled: pass decoded strobes straight to the flops.
  always_comb begin
    wbr_d  = dec_wbr;
    wbin_d = dec_wbin;
  end

  // Memory-source select flop, cleared asynchronously by reset.
  always_ff @(posedge t3 or negedge rst) begin
    if (!rst) wbin_q <= 1'b0;
    else      wbin_q <= wbin_d;
  end

  assign wbin = wbin_q;
`else
  // Load path disabled: wbin_d only marks LDA, so masking with it turns LDA into a no-write.
  always_comb begin
    wbr_d = dec_wbr & ~dec_wbin;
  end

  assign wbin = 1'b0;
`endif

  // Register-write enable flop, cleared asynchronously by reset.
  always_ff @(posedge t3 or negedge rst) begin
    if (!rst) wbr_q <= 1'b0;
    else      wbr_q <= wbr_d;
  end

  assign wbr = wbr_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed test-plan cases plus randomized opcodes
// checked against a rule-level reference model.
module tb_wb_ctrl;

  logic        t3;
  logic        rst;
  logic [15:0] ir;
  logic        wbr;
  logic        wbin;

  int unsigned n_tests;
  int unsigned n_fail;

`ifdef WB_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  wb_ctrl dut (
    .t3   (t3),
    .rst  (rst),
    .ir   (ir),
    .wbr  (wbr),
    .wbin (wbin)
  );

  initial t3 = 1'b0;
  always #5 t3 = ~t3;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {wbr,wbin}=%b required %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: ALU-class opcodes 1..7 write the ALU result; LDA writes memory data
  // only when the load path is built in; everything else writes nothing.
  function automatic logic [1:0] model(input logic [15:0] instr);
    int unsigned op;
    logic w, m;
    op = int'(instr >> 12);
    m  = LOAD_EN && (op == 9);
    w  = (op >= 1 && op <= 7) || m;
    return {w, m};
  endfunction

  // Present an instruction while t3 is low, then check just after the rising edge.
  task automatic step(input string tag, input logic [15:0] v, input logic [1:0] exp);
    @(negedge t3);
    ir = v;
    @(posedge t3);
    #1;
    check(tag, {wbr, wbin}, exp);
  endtask

  logic [1:0]  ld_exp;
  logic [15:0] seq_ir  [5];
  logic [1:0]  seq_exp [5];
  logic [15:0] nw_ir   [6];
  logic [15:0] r;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ld_exp  = LOAD_EN ? 2'b11 : 2'b00;

    // Reset held while t3 toggles
    rst = 1'b0;
    ir  = 16'h3000;
    #1;
    check("reset_init", {wbr, wbin}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(posedge t3);
      #1;
      check("reset_hold", {wbr, wbin}, 2'b00);
    end
    @(negedge t3);
    rst = 1'b1;
    #1;
    check("reset_release", {wbr, wbin}, 2'b00);

    // ALU op and load
    step("alu_mov", 16'h3000, 2'b10);
    step("load",    16'h9000, ld_exp);

    // Sequence
    seq_ir  = '{16'h3000, 16'h9000, 16'h2000, 16'h7000, 16'h0000};
    seq_exp = '{2'b10, ld_exp, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 5; i++) step("sequence", seq_ir[i], seq_exp[i]);

    // Non-writing ops
    nw_ir = '{16'h8000, 16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hF000};
    for (int i = 0; i < 6; i++) step("nonwrite", nw_ir[i], 2'b00);

    // Mid-cycle change while t3 high; identical opcodes stay steady
    step("midchg_pre", 16'h3ABC, 2'b10);
    #1;
    ir = 16'h0000;
    @(negedge t3);
    #1;
    check("midchg_hold", {wbr, wbin}, 2'b10);
    @(posedge t3);
    #1;
    check("midchg_next", {wbr, wbin}, 2'b00);
    step("steady_a", 16'h1111, 2'b10);
    @(negedge t3);
    check("steady_mid", {wbr, wbin}, 2'b10);
    step("steady_b", 16'h1222, 2'b10);

    // Reset asserted mid-instruction while wbr=1
    step("midrst_pre", 16'h9000, ld_exp);
    step("midrst_pre2", 16'h3000, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_clear", {wbr, wbin}, 2'b00);
    @(posedge t3);
    #1;
    check("midrst_hold", {wbr, wbin}, 2'b00);
    @(negedge t3);
    rst = 1'b1;
    #1;
    check("midrst_release", {wbr, wbin}, 2'b00);
    step("midrst_first", 16'h5000, 2'b10);

    // Randomized instructions, including occasional changes while t3 is high
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      step("random", r, model(r));
      if ($urandom_range(0, 3) == 0) begin
        ir = 16'($urandom);
        @(negedge t3);
        #1;
        check("random_hold", {wbr, wbin}, model(r));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
